// File: rtl/st_audio_sample_packer.sv
// Pairs strobed L/R 16-bit samples into {left,right} words, buffers them, presents an Avalon-ST source.
// Define PACKER_CHAN_CHECK_EN to check in_channel order and count sync errors.
module st_audio_sample_packer #(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_channel,
    input  logic [15:0]       in_sample,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   level,
    output logic [CNT_W-1:0]  overflow_count,
    output logic [CNT_W-1:0]  sync_err_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {WAIT_L = 1'b0, WAIT_R = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [15:0]                  left_q, left_d;
    logic [DEPTH-1:0][31:0]       mem_q, mem_d;
    logic [ADDR_W-1:0]            wr_q, wr_d, rd_q, rd_d;
    logic [ADDR_W:0]              cnt_q, cnt_d;
    logic [CNT_W-1:0]             ovf_q, ovf_d;
    logic [31:0]                  out_data_q, out_data_d;
    logic                         push, pop, push_ok, full, sync_inc;
    logic [31:0]                  word;

    // Pairing FSM; a clear cycle swallows any strobe.
    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        push     = 1'b0;
        sync_inc = 1'b0;
        word     = {left_q, in_sample};
        if (clear) begin
            state_d = WAIT_L;
            left_d  = '0;
        end else if (in_valid) begin
            case (state_q)
                WAIT_L: begin
`ifdef PACKER_CHAN_CHECK_EN
                    if (in_channel) begin
                        sync_inc = 1'b1;
                    end else begin
                        left_d  = in_sample;
                        state_d = WAIT_R;
                    end
`else
                    left_d  = in_sample;
                    state_d = WAIT_R;
`endif
                end
                default: begin
`ifdef PACKER_CHAN_CHECK_EN
                    if (!in_channel) begin
                        left_d   = in_sample;
                        sync_inc = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = WAIT_L;
                    end
`else
                    push    = 1'b1;
                    state_d = WAIT_L;
`endif
                end
            endcase
        end
    end

    // A full buffer still accepts a word when the head leaves in the same cycle.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        full    = (cnt_q == DEPTH_C);
        pop     = (cnt_q != '0) && out_ready && !clear;
        push_ok = push && (!full || pop);
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = word;
                wr_d        = wr_q + ADDR_W'(1);
            end else if (push && ovf_q != '1) begin
                ovf_d = ovf_q + CNT_W'(1);
            end
            if (pop) rd_d = rd_q + ADDR_W'(1);
            if (push_ok && !pop) cnt_d = cnt_q + (ADDR_W + 1)'(1);
            else if (!push_ok && pop) cnt_d = cnt_q - (ADDR_W + 1)'(1);
        end
        out_data_d = mem_d[rd_d];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_L;
            left_q     <= '0;
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end

`ifdef PACKER_CHAN_CHECK_EN
    logic [CNT_W-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = sync_q;
        if (sync_inc && sync_q != '1) sync_d = sync_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

    assign sync_err_count = sync_q;
`else
    logic unused_chan;
    assign unused_chan    = &{1'b0, in_channel, sync_inc};
    assign sync_err_count = '0;
`endif

    assign out_data       = out_data_q;
    assign out_valid      = (cnt_q != '0);
    assign level          = cnt_q;
    assign overflow_count = ovf_q;
endmodule

// File: tb/tb_st_audio_sample_packer.sv
// Scoreboard bench for st_audio_sample_packer: expected words queued at stimulus, checked on handshake.
module tb_st_audio_sample_packer;
    logic        clock = 1'b0;
    logic        reset, clear, in_valid, in_channel, out_ready;
    logic [15:0] in_sample;
    logic [31:0] out_data;
    logic        out_valid;
    logic [2:0]  level;
    logic [15:0] overflow_count, sync_err_count;

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    st_audio_sample_packer #(.ADDR_W(2), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_channel(in_channel), .in_sample(in_sample),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow_count(overflow_count), .sync_err_count(sync_err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Handshake is stable at the falling edge; the word leaves on the next rising edge.
    always @(negedge clock) begin
        if (!reset && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_word", out_data, 32'hxxxx_xxxx);
            else                   chk("word", out_data, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic ch, input logic [15:0] s);
        in_valid = 1'b1; in_channel = ch; in_sample = s;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pair(input logic [15:0] l, input logic [15:0] r, input bit accepted);
        strobe(1'b0, l);
        strobe(1'b1, r);
        if (accepted) exp_q.push_back({l, r});
    endtask

    task automatic drain();
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            if (level == 0 && !out_valid) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_channel = 1'b0;
        in_sample = '0; out_ready = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow_count, 0);
        chk("rst_sync", sync_err_count, 0);
        reset = 1'b0;
        tick();

        // Single pair, one-cycle latency, one-cycle valid
        out_ready = 1'b1;
        pair(16'h1234, 16'hABCD, 1'b1);
        chk("t1_valid_on", out_valid, 1);
        chk("t1_level_on", level, 1);
        tick();
        chk("t1_valid_off", out_valid, 0);
        chk("t1_level_off", level, 0);

        // Overflow: five pairs into a four-deep buffer
        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) pair(16'(n), 16'(n + 'h100), n <= 4);
        chk("t2_level", level, 4);
        chk("t2_ovf", overflow_count, 1);
        chk("t2_head", out_data, 32'h0001_0101);
        drain();

        // Full buffer with a simultaneous pop accepts the new word
        out_ready = 1'b0;
        for (int n = 6; n <= 9; n++) pair(16'(n), 16'(n + 'h100), 1'b1);
        strobe(1'b0, 16'h000A);
        chk("t3_level_full", level, 4);
        out_ready = 1'b1;
        strobe(1'b1, 16'h010A);
        exp_q.push_back(32'h000A_010A);
        chk("t3_level_same", level, 4);
        chk("t3_ovf_same", overflow_count, 1);
        drain();

        // Channel checking
`ifdef PACKER_CHAN_CHECK_EN
        strobe(1'b0, 16'h1111);
        strobe(1'b0, 16'h2222);
        strobe(1'b1, 16'h3333);
        exp_q.push_back(32'h2222_3333);
        chk("t4_sync1", sync_err_count, 1);
        strobe(1'b1, 16'h4444);
        chk("t4_sync2", sync_err_count, 2);
        drain();
        chk("t4_level", level, 0);
`else
        strobe(1'b1, 16'h1111);
        strobe(1'b0, 16'h3333);
        exp_q.push_back(32'h1111_3333);
        chk("t4_sync_tied", sync_err_count, 0);
        drain();
`endif

        // clear with three words buffered and a held left
        out_ready = 1'b0;
        for (int n = 0; n < 3; n++) pair(16'(n + 'h20), 16'(n + 'h30), 1'b1);
        strobe(1'b0, 16'h7777);
        chk("t5_level_pre", level, 3);
        clear = 1'b1;
        in_valid = 1'b1; in_channel = 1'b1; in_sample = 16'hDEAD;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        chk("t5_level", level, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_ovf_kept", overflow_count, 1);
`ifdef PACKER_CHAN_CHECK_EN
        chk("t5_sync_kept", sync_err_count, 2);
`endif
        out_ready = 1'b1;
        pair(16'h0BAD, 16'hBEEF, 1'b1);
        drain();

        // Reset mid-pair discards the held left
        strobe(1'b0, 16'h6666);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_ovf", overflow_count, 0);
        tick();
        reset = 1'b0;
        tick();
        strobe(1'b1, 16'h5555);
        tick();
        tick();
        chk("t6_no_word_valid", out_valid, 0);
        chk("t6_no_word_level", level, 0);
`ifdef PACKER_CHAN_CHECK_EN
        chk("t6_sync", sync_err_count, 1);
`else
        chk("t6_sync", sync_err_count, 0);
`endif
        chk("t6_scoreboard", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
